// File: rtl/orb_pkg.sv
// Shared constants and types for the Orbita M-series telemetry link: word
// format, sync pattern, per-group frame geometry and receiver state encoding.
package orb_pkg;

    localparam int ORB_WORD_W = 12;
    localparam logic [ORB_WORD_W-1:0] ORB_SYNC_WORD = 12'hE24;

    // Frame geometry per group output; ADDR_W satisfies 2**ADDR_W == FRAME_WORDS.
    localparam int ORB_M16_FRAME_WORDS = 2048;
    localparam int ORB_M16_ADDR_W      = 11;
    localparam int ORB_M8_FRAME_WORDS  = 1024;
    localparam int ORB_M8_ADDR_W       = 10;
    localparam int ORB_M2_FRAME_WORDS  = 256;
    localparam int ORB_M2_ADDR_W       = 8;
    localparam int ORB_M1_FRAME_WORDS  = 128;
    localparam int ORB_M1_ADDR_W       = 7;

    // Receiver framer state.
    typedef enum logic {
        RX_HUNT   = 1'b0,
        RX_LOCKED = 1'b1
    } rx_state_t;

    // Width of a saturating counter that must be able to hold max_count.
    function automatic int orb_count_w(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/orb_bit_sampler.sv
// Bit-timing recovery for one NRZ line: 2-FF synchroniser, one history FF for
// edge detection and a phase counter that picks a sample half a bit after the
// most recent edge. bit_valid is a combinational one-cycle pulse.
module orb_bit_sampler #(
    parameter int OVS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic serial,
    output logic bit_value,
    output logic bit_valid
);

    localparam int PH_W = $clog2(OVS);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);

    logic            meta_reg;
    logic            sync_reg;
    logic            hist_reg;
    logic            edge_seen;
    logic [PH_W-1:0] phase_reg;
    logic [PH_W-1:0] phase_next;

    // Synchronise the asynchronous line and keep one sample of history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            hist_reg <= 1'b0;
        end else begin
            meta_reg <= serial;
            sync_reg <= meta_reg;
            hist_reg <= sync_reg;
        end
    end

    assign edge_seen = sync_reg ^ hist_reg;

    // Phase restarts on every edge, otherwise free-runs modulo OVS.
    always_comb begin
        phase_next = phase_reg;
        if (edge_seen) begin
            phase_next = '0;
        end else if (phase_reg == PH_LAST) begin
            phase_next = '0;
        end else begin
            phase_next = phase_reg + 1'b1;
        end
    end

    // Phase counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_next;
        end
    end

    // An edge in the mid-phase cycle suppresses the sample; the line is
    // stable (sync_reg == hist_reg) whenever a sample is taken.
    assign bit_valid = (phase_reg == PH_MID) && !edge_seen;
    assign bit_value = sync_reg;

endmodule

// File: rtl/orb_frame_rx.sv
// Orbita M-series frame receiver: recovers bits from the serial line, hunts for
// the sync word, then deserialises MSB-first words and strobes each one out
// with its in-frame address. Lock is dropped after MISS_MAX consecutive bad
// sync words.
module orb_frame_rx
    import orb_pkg::*;
#(
    parameter int                OVS         = 8,
    parameter int                WORD_W      = ORB_WORD_W,
    parameter int                FRAME_WORDS = ORB_M16_FRAME_WORDS,
    parameter int                ADDR_W      = ORB_M16_ADDR_W,
    parameter logic [WORD_W-1:0] SYNC_WORD   = WORD_W'(ORB_SYNC_WORD),
    parameter int                MISS_MAX    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iSerial,
    output logic [WORD_W-1:0] oWord,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oWrEn,
    output logic              oFrameStart,
    output logic              oLock,
    output logic              oSyncErr
);

    localparam int CNT_W  = $clog2(WORD_W);
    localparam int MISS_W = orb_count_w(MISS_MAX);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(MISS_MAX);

    logic bit_value;
    logic bit_valid;

    orb_bit_sampler #(
        .OVS (OVS)
    ) u_sampler (
        .clk       (clk),
        .reset     (reset),
        .serial    (iSerial),
        .bit_value (bit_value),
        .bit_valid (bit_valid)
    );

    rx_state_t          state_reg,       state_next;
    logic [WORD_W-1:0]  shift_reg,       shift_next;
    logic [CNT_W-1:0]   bit_cnt_reg,     bit_cnt_next;
    logic [ADDR_W-1:0]  addr_reg,        addr_next;
    logic [MISS_W-1:0]  miss_reg,        miss_next;
    logic [WORD_W-1:0]  word_reg,        word_next;
    logic [ADDR_W-1:0]  addr_out_reg,    addr_out_next;
    logic               wr_en_reg,       wr_en_next;
    logic               frame_start_reg, frame_start_next;
    logic               lock_reg,        lock_next;
    logic               sync_err_reg,    sync_err_next;
    logic [WORD_W-1:0]  shifted;
    logic [MISS_W-1:0]  miss_inc;

    assign shifted = {shift_reg[WORD_W-2:0], bit_value};

    // Framer: sync hunt, word assembly, address sequencing and strobes.
    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        bit_cnt_next     = bit_cnt_reg;
        addr_next        = addr_reg;
        miss_next        = miss_reg;
        word_next        = word_reg;
        addr_out_next    = addr_out_reg;
        wr_en_next       = 1'b0;
        frame_start_next = 1'b0;
        lock_next        = lock_reg;
        sync_err_next    = 1'b0;
        miss_inc         = (miss_reg >= MISS_LIM) ? MISS_LIM : miss_reg + 1'b1;

        if (bit_valid) begin
            shift_next = shifted;
            case (state_reg)
                RX_HUNT: begin
                    // The sync word found in hunt is itself written as word 0.
                    if (shifted == SYNC_WORD) begin
                        state_next       = RX_LOCKED;
                        wr_en_next       = 1'b1;
                        word_next        = shifted;
                        addr_out_next    = '0;
                        frame_start_next = 1'b1;
                        lock_next        = 1'b1;
                        bit_cnt_next     = '0;
                        addr_next        = ADDR_W'(1);
                        miss_next        = '0;
                    end
                end
                RX_LOCKED: begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        bit_cnt_next  = '0;
                        wr_en_next    = 1'b1;
                        word_next     = shifted;
                        addr_out_next = addr_reg;
                        addr_next     = (addr_reg == ADDR_LAST) ? '0 : addr_reg + 1'b1;
                        if (addr_reg == '0) begin
                            frame_start_next = 1'b1;
                            if (shifted == SYNC_WORD) begin
                                miss_next = '0;
                            end else begin
                                // Bad sync is still written; shift reg is kept so
                                // the hunt continues seamlessly on the next bit.
                                sync_err_next = 1'b1;
                                miss_next     = miss_inc;
                                if (miss_inc >= MISS_LIM) begin
                                    state_next = RX_HUNT;
                                    lock_next  = 1'b0;
                                end
                            end
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = RX_HUNT;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= RX_HUNT;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            addr_reg        <= '0;
            miss_reg        <= '0;
            word_reg        <= '0;
            addr_out_reg    <= '0;
            wr_en_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            lock_reg        <= 1'b0;
            sync_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            addr_reg        <= addr_next;
            miss_reg        <= miss_next;
            word_reg        <= word_next;
            addr_out_reg    <= addr_out_next;
            wr_en_reg       <= wr_en_next;
            frame_start_reg <= frame_start_next;
            lock_reg        <= lock_next;
            sync_err_reg    <= sync_err_next;
        end
    end

    assign oWord       = word_reg;
    assign oAddr       = addr_out_reg;
    assign oWrEn       = wr_en_reg;
    assign oFrameStart = frame_start_reg;
    assign oLock       = lock_reg;
    assign oSyncErr    = sync_err_reg;

endmodule

// File: tb/tb_orb_frame_rx.sv
// Directed bench for orb_frame_rx with a reduced 16-word frame. A negedge
// monitor records every write strobe; each test task drives the serial line
// and checks the recorded strobes and outputs against hand-derived values.
`timescale 1ns/1ps
module tb_orb_frame_rx;

    localparam int OVS = 8;
    localparam int WW  = 12;
    localparam int FW  = 16;
    localparam int AW  = 4;
    localparam logic [WW-1:0] SYNC = 12'hE24;
    localparam logic [WW-1:0] BAD  = 12'hE25;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          iSerial = 1'b0;
    logic [WW-1:0] oWord;
    logic [AW-1:0] oAddr;
    logic          oWrEn, oFrameStart, oLock, oSyncErr;

    orb_frame_rx #(
        .OVS(OVS), .WORD_W(WW), .FRAME_WORDS(FW), .ADDR_W(AW),
        .SYNC_WORD(SYNC), .MISS_MAX(2)
    ) dut (
        .clk(clk), .reset(reset), .iSerial(iSerial),
        .oWord(oWord), .oAddr(oAddr), .oWrEn(oWrEn),
        .oFrameStart(oFrameStart), .oLock(oLock), .oSyncErr(oSyncErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [WW-1:0] word;
        logic [AW-1:0] addr;
        logic          fs;
        logic          lock;
        logic          serr;
    } rec_t;

    rec_t          caps[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            pcnt = 0;
    int            stray = 0;
    logic          prev_wren = 1'b0;
    int            jit_prev = 0;
    int            last_bit_cyc = 0;
    logic [WW-1:0] win = '0;

    always @(posedge clk) pcnt++;

    // Strobe recorder plus protocol-rule violation counter.
    always @(negedge clk) begin
        rec_t r;
        if (oWrEn) begin
            r.cyc = pcnt; r.word = oWord; r.addr = oAddr;
            r.fs = oFrameStart; r.lock = oLock; r.serr = oSyncErr;
            caps.push_back(r);
        end
        if (oWrEn && prev_wren) stray++;
        if ((oFrameStart || oSyncErr) && !oWrEn) stray++;
        if (oFrameStart && oAddr != '0) stray++;
        if (oSyncErr && !oFrameStart) stray++;
        prev_wren = oWrEn;
    end

    function automatic logic [WW-1:0] data_word(input int f, input int i);
        return 12'((i * 341 + f * 935 + 195) & 12'hFFF);
    endfunction

    // One bit on the line, driven at a negedge; optional +-1 clk edge jitter.
    task automatic send_bit(input logic b, input bit jitter);
        int jn, len;
        jn = jitter ? int'($urandom_range(2, 0)) - 1 : 0;
        len = OVS + jn - jit_prev;
        jit_prev = jn;
        iSerial = b;
        last_bit_cyc = pcnt;
        win = {win[WW-2:0], b};
        repeat (len) @(negedge clk);
    endtask

    task automatic send_word(input logic [WW-1:0] w, input bit jitter);
        for (int i = WW - 1; i >= 0; i--) send_bit(w[i], jitter);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
    endtask

    // Word 0 = w0, words >= zero_from are 0, others follow data_word(f, i).
    task automatic send_frame(input logic [WW-1:0] w0, input int f, input int zero_from, input bit jitter);
        send_word(w0, jitter);
        for (int i = 1; i < FW; i++)
            send_word((i >= zero_from) ? 12'h000 : data_word(f, i), jitter);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        iSerial = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        caps.delete();
        stray = 0;
        win = '0;
        jit_prev = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        if (oWord !== '0) begin n_bad++; $display("FAIL reset_word: got %h expected 000", oWord); end
        n_cmp++;
        if (oAddr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", oAddr); end
        n_cmp++;
        if ({oWrEn, oFrameStart, oLock, oSyncErr} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 0000", {oWrEn, oFrameStart, oLock, oSyncErr});
        end
        n_cmp++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_idle();
        do_reset();
        repeat (20 * FW * WW * OVS) @(negedge clk);
        if (caps.size() != 0) begin n_bad++; $display("FAIL idle_strobes: got %0d expected 0", caps.size()); end
        n_cmp++;
        if ({oWord, oAddr, oWrEn, oFrameStart, oLock, oSyncErr} !== '0) begin
            n_bad++; $display("FAIL idle_outputs: got word %h addr %h flags %b expected all 0",
                              oWord, oAddr, {oWrEn, oFrameStart, oLock, oSyncErr});
        end
        n_cmp++;
    endtask

    task automatic test_loopback();
        logic [WW-1:0] ew;
        logic [AW-1:0] ea;
        do_reset();
        idle_bits(2);
        for (int f = 0; f < 3; f++) send_frame(SYNC, f, FW, 1'b0);
        idle_bits(2);
        if (caps.size() != 3 * FW) begin n_bad++; $display("FAIL loop_count: got %0d expected %0d", caps.size(), 3 * FW); end
        n_cmp++;
        for (int i = 0; i < caps.size() && i < 3 * FW; i++) begin
            ea = AW'(i % FW);
            ew = (ea == '0) ? SYNC : data_word(i / FW, i % FW);
            if ({caps[i].word, caps[i].addr, caps[i].fs, caps[i].lock, caps[i].serr} !== {ew, ea, (ea == '0), 1'b1, 1'b0}) begin
                n_bad++; $display("FAIL loop_rec[%0d]: got word %h addr %0d fs %b lock %b serr %b expected word %h addr %0d fs %b lock 1 serr 0",
                                  i, caps[i].word, caps[i].addr, caps[i].fs, caps[i].lock, caps[i].serr, ew, ea, (ea == '0));
            end
            n_cmp++;
            if (i > 0) begin
                if (caps[i].cyc - caps[i-1].cyc != WW * OVS) begin
                    n_bad++; $display("FAIL loop_spacing[%0d]: got %0d expected %0d", i, caps[i].cyc - caps[i-1].cyc, WW * OVS);
                end
                n_cmp++;
            end
        end
        if (stray != 0) begin n_bad++; $display("FAIL loop_protocol: got %0d violations expected 0", stray); end
        n_cmp++;
    endtask

    task automatic test_sync_hunt();
        logic b;
        int   sync_last;
        do_reset();
        idle_bits(2);
        for (int i = 0; i < 40; i++) begin
            b = 1'($urandom_range(1, 0));
            if ({win[WW-2:0], b} == SYNC) b = ~b;
            send_bit(b, 1'b0);
        end
        if (caps.size() != 0 || oLock !== 1'b0) begin
            n_bad++; $display("FAIL hunt_preamble: got %0d strobes lock %b expected 0 strobes lock 0", caps.size(), oLock);
        end
        n_cmp++;
        send_word(SYNC, 1'b0);
        sync_last = last_bit_cyc;
        idle_bits(2);
        if (caps.size() != 1) begin n_bad++; $display("FAIL hunt_count: got %0d expected 1", caps.size()); end
        n_cmp++;
        if (caps.size() >= 1) begin
            if ({caps[0].word, caps[0].addr, caps[0].fs, caps[0].lock, caps[0].serr} !== {SYNC, 4'd0, 1'b1, 1'b1, 1'b0}) begin
                n_bad++; $display("FAIL hunt_rec: got word %h addr %0d fs %b lock %b serr %b expected word e24 addr 0 fs 1 lock 1 serr 0",
                                  caps[0].word, caps[0].addr, caps[0].fs, caps[0].lock, caps[0].serr);
            end
            n_cmp++;
            // Bit is driven half a clock before its capturing edge, so the
            // strobe (OVS/2+3 after capture) lands OVS/2+4 posedges after the drive.
            if (caps[0].cyc - sync_last != OVS / 2 + 4) begin
                n_bad++; $display("FAIL hunt_latency: got %0d expected %0d", caps[0].cyc - sync_last, OVS / 2 + 4);
            end
            n_cmp++;
        end
    endtask

    task automatic test_sync_errors();
        do_reset();
        idle_bits(2);
        send_frame(SYNC, 30, FW, 1'b0);
        send_frame(BAD, 31, FW, 1'b0);
        if (oLock !== 1'b1) begin n_bad++; $display("FAIL serr_lock_after_one: got %b expected 1", oLock); end
        n_cmp++;
        send_frame(SYNC, 32, FW, 1'b0);
        send_frame(BAD, 33, FW, 1'b0);
        send_frame(BAD, 34, 1, 1'b0);
        if (oLock !== 1'b0) begin n_bad++; $display("FAIL serr_lock_after_two: got %b expected 0", oLock); end
        n_cmp++;
        send_frame(SYNC, 35, FW, 1'b0);
        idle_bits(2);
        if (caps.size() != 5 * FW + 1) begin n_bad++; $display("FAIL serr_count: got %0d expected %0d", caps.size(), 5 * FW + 1); end
        n_cmp++;
        if (caps.size() >= 5 * FW + 1) begin
            if ({caps[16].word, caps[16].addr, caps[16].fs, caps[16].lock, caps[16].serr} !== {BAD, 4'd0, 1'b1, 1'b1, 1'b1}) begin
                n_bad++; $display("FAIL serr_first: got word %h addr %0d fs %b lock %b serr %b expected e25 0 1 1 1",
                                  caps[16].word, caps[16].addr, caps[16].fs, caps[16].lock, caps[16].serr);
            end
            n_cmp++;
            if ({caps[17].word, caps[17].addr, caps[17].lock} !== {data_word(31, 1), 4'd1, 1'b1}) begin
                n_bad++; $display("FAIL serr_data_after: got word %h addr %0d lock %b expected %h 1 1",
                                  caps[17].word, caps[17].addr, caps[17].lock, data_word(31, 1));
            end
            n_cmp++;
            if ({caps[32].word, caps[32].fs, caps[32].lock, caps[32].serr} !== {SYNC, 1'b1, 1'b1, 1'b0}) begin
                n_bad++; $display("FAIL serr_recover: got word %h fs %b lock %b serr %b expected e24 1 1 0",
                                  caps[32].word, caps[32].fs, caps[32].lock, caps[32].serr);
            end
            n_cmp++;
            if ({caps[48].word, caps[48].lock, caps[48].serr} !== {BAD, 1'b1, 1'b1}) begin
                n_bad++; $display("FAIL serr_miss1: got word %h lock %b serr %b expected e25 1 1",
                                  caps[48].word, caps[48].lock, caps[48].serr);
            end
            n_cmp++;
            if ({caps[64].word, caps[64].addr, caps[64].fs, caps[64].lock, caps[64].serr} !== {BAD, 4'd0, 1'b1, 1'b0, 1'b1}) begin
                n_bad++; $display("FAIL serr_miss2: got word %h addr %0d fs %b lock %b serr %b expected e25 0 1 0 1",
                                  caps[64].word, caps[64].addr, caps[64].fs, caps[64].lock, caps[64].serr);
            end
            n_cmp++;
            if ({caps[65].word, caps[65].addr, caps[65].fs, caps[65].lock, caps[65].serr} !== {SYNC, 4'd0, 1'b1, 1'b1, 1'b0}) begin
                n_bad++; $display("FAIL serr_relock: got word %h addr %0d fs %b lock %b serr %b expected e24 0 1 1 0",
                                  caps[65].word, caps[65].addr, caps[65].fs, caps[65].lock, caps[65].serr);
            end
            n_cmp++;
            if ({caps[80].word, caps[80].addr} !== {data_word(35, 15), 4'd15}) begin
                n_bad++; $display("FAIL serr_last: got word %h addr %0d expected %h 15", caps[80].word, caps[80].addr, data_word(35, 15));
            end
            n_cmp++;
        end
        if (stray != 0) begin n_bad++; $display("FAIL serr_protocol: got %0d violations expected 0", stray); end
        n_cmp++;
    endtask

    task automatic test_jitter();
        int            errs;
        logic [WW-1:0] ew;
        do_reset();
        idle_bits(2);
        for (int f = 0; f < 4; f++) send_frame(SYNC, 20 + f, FW, 1'b1);
        idle_bits(2);
        if (caps.size() != 4 * FW) begin n_bad++; $display("FAIL jit_count: got %0d expected %0d", caps.size(), 4 * FW); end
        n_cmp++;
        errs = 0;
        for (int i = 0; i < caps.size() && i < 4 * FW; i++) begin
            ew = (i % FW == 0) ? SYNC : data_word(20 + i / FW, i % FW);
            if (caps[i].word !== ew || caps[i].addr !== AW'(i % FW) || caps[i].lock !== 1'b1 || caps[i].serr !== 1'b0) errs++;
        end
        if (errs != 0) begin n_bad++; $display("FAIL jit_words: got %0d bad records expected 0", errs); end
        n_cmp++;
        if (stray != 0) begin n_bad++; $display("FAIL jit_protocol: got %0d violations expected 0", stray); end
        n_cmp++;
    endtask

    task automatic test_reset_midword();
        do_reset();
        idle_bits(2);
        send_frame(SYNC, 10, FW, 1'b0);
        send_word(SYNC, 1'b0);
        for (int i = 1; i < 7; i++) send_word(data_word(11, i), 1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
        if (oLock !== 1'b1 || oAddr !== 4'd6) begin
            n_bad++; $display("FAIL rst_before: got lock %b addr %0d expected lock 1 addr 6", oLock, oAddr);
        end
        n_cmp++;
        iSerial = 1'b0;
        reset = 1'b0;
        #1;
        if ({oWord, oAddr, oWrEn, oFrameStart, oLock, oSyncErr} !== '0) begin
            n_bad++; $display("FAIL rst_immediate: got word %h addr %0d flags %b expected all 0",
                              oWord, oAddr, {oWrEn, oFrameStart, oLock, oSyncErr});
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b1;
        repeat (OVS - 1) @(negedge clk);
        for (int i = 7; i < 12; i++) send_bit(1'b0, 1'b0);
        for (int i = 8; i < FW; i++) send_word(12'h000, 1'b0);
        if (oLock !== 1'b0) begin n_bad++; $display("FAIL rst_hunting: got lock %b expected 0", oLock); end
        n_cmp++;
        send_frame(SYNC, 12, FW, 1'b0);
        idle_bits(2);
        if (caps.size() != 2 * FW + 7) begin n_bad++; $display("FAIL rst_count: got %0d expected %0d", caps.size(), 2 * FW + 7); end
        n_cmp++;
        if (caps.size() >= 2 * FW + 7) begin
            if ({caps[23].word, caps[23].addr, caps[23].fs, caps[23].lock} !== {SYNC, 4'd0, 1'b1, 1'b1}) begin
                n_bad++; $display("FAIL rst_relock: got word %h addr %0d fs %b lock %b expected e24 0 1 1",
                                  caps[23].word, caps[23].addr, caps[23].fs, caps[23].lock);
            end
            n_cmp++;
            if ({caps[38].word, caps[38].addr} !== {data_word(12, 15), 4'd15}) begin
                n_bad++; $display("FAIL rst_last: got word %h addr %0d expected %h 15", caps[38].word, caps[38].addr, data_word(12, 15));
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_loopback();
        test_sync_hunt();
        test_sync_errors();
        test_jitter();
        test_reset_midword();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
